// File: rtl/ln_iter.sv
// rtl/ln_iter.sv - sequential fixed-point ln(x), one shift-and-add bit per clock
// Optional build macro: LN_ITER_ROUND_EN (round half-up in FINAL instead of floor).
module ln_iter #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ITER   = FRAC_W,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int IFW   = FRAC_W + GUARD;
  localparam int M_W   = IFW + 2;
  localparam int ACC_W = IFW + 1;
  localparam int R_W   = IFW + 8;
  localparam int P_W   = $clog2(DATA_W);
  localparam int I_W   = $clog2(ITER + 1);

  function automatic logic [ITER*ACC_W-1:0] build_lut();
    logic [ITER*ACC_W-1:0] v;
    v = '0;
    for (int j = 1; j <= ITER; j++)
      v[(j-1)*ACC_W +: ACC_W] = ACC_W'($rtoi($ln(1.0 + 2.0 ** (-j)) * (2.0 ** IFW) + 0.5));
    return v;
  endfunction

  localparam logic [ITER*ACC_W-1:0] LUT_P = build_lut();
  localparam logic [ACC_W-1:0]      LN2   = ACC_W'($rtoi($ln(2.0) * (2.0 ** IFW) + 0.5));

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ITER,
    S_FINAL,
    S_DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  x_r;
  logic [M_W-1:0]     m_r;
  logic [ACC_W-1:0]   acc_r;
  logic [I_W-1:0]     i_r;
  logic signed [6:0]  kp1_r;

  logic [P_W-1:0]          p;
  logic [DATA_W+IFW-1:0]   xw;
  logic [M_W-1:0]          m_n;
  logic signed [6:0]       kp1_n;
  logic [M_W-1:0]          t;
  logic [ACC_W-1:0]        lut_i;
  logic signed [R_W-1:0]   r_full;
  logic signed [R_W-1:0]   r_adj;
  logic [DATA_W-1:0]       res;

  // Leading-one position and normalisation of the captured operand to [1,2).
  always_comb begin
    p = '0;
    for (int b = 0; b < DATA_W; b++)
      if (x_r[b]) p = P_W'(b);
    xw    = {x_r, {IFW{1'b0}}};
    m_n   = M_W'(xw >> p);
    kp1_n = 7'(p) - 7'(FRAC_W - 1);
  end

  always_comb begin
    t     = m_r + (m_r >> i_r);
    lut_i = '0;
    if (i_r != '0)
      lut_i = LUT_P[(int'(i_r) - 1)*ACC_W +: ACC_W];
  end

  // ln(x) = (k+1)*ln2 - sum of accepted ln(1+2^-i) terms.
  always_comb begin
    r_full = R_W'(kp1_r) * $signed(R_W'(LN2)) - $signed(R_W'(acc_r));
`ifdef LN_ITER_ROUND_EN
    r_adj  = r_full + R_W'(2 ** (GUARD - 1));
`else
    r_adj  = r_full;
`endif
    res    = DATA_W'(r_adj >>> GUARD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      x_r       <= '0;
      m_r       <= '0;
      acc_r     <= '0;
      i_r       <= '0;
      kp1_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_r      <= in_data;
            in_ready <= 1'b0;
            if (in_data == '0) begin
              out_data  <= {1'b1, {(DATA_W-1){1'b0}}};
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          m_r   <= m_n;
          kp1_r <= kp1_n;
          acc_r <= '0;
          i_r   <= I_W'(1);
          state <= S_ITER;
        end
        S_ITER: begin
          if (!t[M_W-1]) begin
            m_r   <= t;
            acc_r <= acc_r + lut_i;
          end
          i_r <= i_r + I_W'(1);
          if (i_r == I_W'(ITER)) state <= S_FINAL;
        end
        S_FINAL: begin
          out_data  <= res;
          out_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
